// File: rtl/stopwatch_counter_pkg.sv
// Shared field moduli, widths and FSM encoding for the stopwatch datapath.
package stopwatch_counter_pkg;

    localparam int MS_MOD  = 1000;
    localparam int SEC_MOD = 60;
    localparam int MIN_MOD = 60;

    localparam int MS_W  = 10;
    localparam int SEC_W = 6;
    localparam int MIN_W = 6;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

endpackage

// File: rtl/stopwatch_counter_if.sv
// Command, preset and time/lap bundle between the controller and the stopwatch core.
interface stopwatch_counter_if
    import stopwatch_counter_pkg::*;
#(
    parameter int HR_BITS = 7
);
    logic               start;
    logic               stop;
    logic               clear;
    logic               lap;
    logic               load;
    logic [MS_W-1:0]    load_ms;
    logic [SEC_W-1:0]   load_s;
    logic [MIN_W-1:0]   load_min;
    logic [HR_BITS-1:0] load_hr;

    logic [MS_W-1:0]    ms;
    logic [SEC_W-1:0]   s;
    logic [MIN_W-1:0]   min;
    logic [HR_BITS-1:0] hr;
    logic [MS_W-1:0]    lap_ms;
    logic [SEC_W-1:0]   lap_s;
    logic [MIN_W-1:0]   lap_min;
    logic [HR_BITS-1:0] lap_hr;
    logic               lap_valid;
    logic               running;
    logic               overflow;

    modport master (
        output start, stop, clear, lap, load, load_ms, load_s, load_min, load_hr,
        input  ms, s, min, hr, lap_ms, lap_s, lap_min, lap_hr, lap_valid, running, overflow
    );

    modport slave (
        input  start, stop, clear, lap, load, load_ms, load_s, load_min, load_hr,
        output ms, s, min, hr, lap_ms, lap_s, lap_min, lap_hr, lap_valid, running, overflow
    );
endinterface

// File: rtl/stopwatch_counter_mod_counter.sv
// Modulo-MOD counter with synchronous load; carry marks the wrap from MOD-1 to 0.
module mod_counter #(
    parameter int MOD = 10,
    parameter int W   = 4
) (
    input  logic         clk,
    input  logic         nreset,
    input  logic         en,
    input  logic         ld,
    input  logic [W-1:0] ld_val,
    output logic [W-1:0] q,
    output logic         carry
);
    logic at_max;

    assign at_max = (q == W'(MOD - 1));
    assign carry  = en && !ld && at_max;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            q <= '0;
        end else if (ld) begin
            q <= ld_val;
        end else if (en) begin
            q <= at_max ? '0 : q + W'(1);
        end
    end
endmodule

// File: rtl/stopwatch_counter.sv
// Run/pause stopwatch: prescaler feeding a ms/s/min/hr carry chain, with lap capture and preset load.
module stopwatch_counter
    import stopwatch_counter_pkg::*;
#(
    parameter int CLK_PER_MS = 50000,
    parameter int HR_BITS    = 7,
    parameter int HR_MAX     = 100,
    parameter int WRAP       = 1
) (
    input  logic               clk,
    input  logic               nreset,
    stopwatch_counter_if.slave bus
);
    localparam int PW = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(CLK_PER_MS - 1);

    function automatic int unsigned clamp_field(int unsigned v, int unsigned m);
        return (v >= m) ? (m - 1) : v;
    endfunction

    state_t             state_q, state_d;
    logic [PW-1:0]      pre_q;
    logic               ovf_q;
    logic               lap_valid_q;
    logic [MS_W-1:0]    ms_q, ms_ld, lap_ms_q;
    logic [SEC_W-1:0]   s_q, s_ld, lap_s_q;
    logic [MIN_W-1:0]   min_q, min_ld, lap_min_q;
    logic [HR_BITS-1:0] hr_q, hr_ld, lap_hr_q;
    logic               load_acc, tick, full, sat_evt, start_ok, ld_all, en_ms;
    logic               c_ms, c_s, c_min, c_hr;

    assign load_acc = bus.load && (state_q != ST_RUN);
    assign ld_all   = bus.clear || load_acc;
    assign tick     = (state_q == ST_RUN) && (pre_q == PRE_LAST);
    assign full     = (ms_q == MS_W'(MS_MOD - 1)) && (s_q == SEC_W'(SEC_MOD - 1)) &&
                      (min_q == MIN_W'(MIN_MOD - 1)) && (hr_q == HR_BITS'(HR_MAX - 1));
    // In saturate mode the chain is frozen at full scale instead of rolling over.
    assign sat_evt  = tick && full && (WRAP == 0);
    assign en_ms    = tick && !bus.clear && !sat_evt;
    assign start_ok = (WRAP != 0) || !ovf_q;

    assign ms_ld  = bus.clear ? '0 : MS_W'(clamp_field(32'(bus.load_ms), MS_MOD));
    assign s_ld   = bus.clear ? '0 : SEC_W'(clamp_field(32'(bus.load_s), SEC_MOD));
    assign min_ld = bus.clear ? '0 : MIN_W'(clamp_field(32'(bus.load_min), MIN_MOD));
    assign hr_ld  = bus.clear ? '0 : HR_BITS'(clamp_field(32'(bus.load_hr), HR_MAX));

    // ---- command decode / next state ----
    always_comb begin
        state_d = state_q;
        if (bus.clear) begin
            state_d = ST_IDLE;
        end else if (load_acc) begin
            state_d = ST_PAUSE;
        end else if (bus.stop) begin
            if (state_q == ST_RUN) state_d = ST_PAUSE;
        end else if (bus.start) begin
            if (state_q != ST_RUN && start_ok) state_d = ST_RUN;
        end
        if (sat_evt && !bus.clear) state_d = ST_PAUSE;
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q <= ST_IDLE;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (ld_all) begin
                ovf_q <= 1'b0;
            end else if (c_hr || sat_evt) begin
                ovf_q <= 1'b1;
            end
        end
    end

    // ---- prescaler: holds in PAUSE so a resume continues mid-millisecond ----
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            pre_q <= '0;
        end else if (ld_all) begin
            pre_q <= '0;
        end else if (state_q == ST_RUN) begin
            pre_q <= tick ? '0 : pre_q + PW'(1);
        end
    end

    // ---- carry chain ----
    mod_counter #(.MOD(MS_MOD), .W(MS_W)) u_ms (
        .clk(clk), .nreset(nreset), .en(en_ms), .ld(ld_all), .ld_val(ms_ld),
        .q(ms_q), .carry(c_ms)
    );
    mod_counter #(.MOD(SEC_MOD), .W(SEC_W)) u_s (
        .clk(clk), .nreset(nreset), .en(c_ms), .ld(ld_all), .ld_val(s_ld),
        .q(s_q), .carry(c_s)
    );
    mod_counter #(.MOD(MIN_MOD), .W(MIN_W)) u_min (
        .clk(clk), .nreset(nreset), .en(c_s), .ld(ld_all), .ld_val(min_ld),
        .q(min_q), .carry(c_min)
    );
    mod_counter #(.MOD(HR_MAX), .W(HR_BITS)) u_hr (
        .clk(clk), .nreset(nreset), .en(c_min), .ld(ld_all), .ld_val(hr_ld),
        .q(hr_q), .carry(c_hr)
    );

    // ---- lap capture: samples the pre-edge time ----
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            lap_valid_q <= 1'b0;
            lap_ms_q    <= '0;
            lap_s_q     <= '0;
            lap_min_q   <= '0;
            lap_hr_q    <= '0;
        end else if (bus.clear) begin
            lap_valid_q <= 1'b0;
            lap_ms_q    <= '0;
            lap_s_q     <= '0;
            lap_min_q   <= '0;
            lap_hr_q    <= '0;
        end else if (bus.lap && state_q != ST_IDLE) begin
            lap_valid_q <= 1'b1;
            lap_ms_q    <= ms_q;
            lap_s_q     <= s_q;
            lap_min_q   <= min_q;
            lap_hr_q    <= hr_q;
        end
    end

    assign bus.ms        = ms_q;
    assign bus.s         = s_q;
    assign bus.min       = min_q;
    assign bus.hr        = hr_q;
    assign bus.lap_ms    = lap_ms_q;
    assign bus.lap_s     = lap_s_q;
    assign bus.lap_min   = lap_min_q;
    assign bus.lap_hr    = lap_hr_q;
    assign bus.lap_valid = lap_valid_q;
    assign bus.running   = (state_q == ST_RUN);
    assign bus.overflow  = ovf_q;
endmodule

// File: doc/stopwatch_counter.md
Name: stopwatch_counter

Overview:
Free-running stopwatch that generates elapsed time in ms/s/min/hr from the system clock through an internal prescaler and a cascaded mod-N counter chain. It replaces the combinational count-to-time conversion with incremental carries, so no dividers are needed. It adds run/pause control, clear, preset load, lap capture and configurable hour wrap/saturate. It sits between the pulse/clock domain and the display formatter.

Parameters:
CLK_PER_MS, 50000, clock cycles per millisecond increment (>=1)
HR_BITS, 7, width of hour field
HR_MAX, 100, hour modulus; hr counts 0..HR_MAX-1 (HR_MAX <= 2**HR_BITS)
WRAP, 1, 1 = roll over to 00:00:00.000 at full scale; 0 = saturate and pause

Ports:
clk  in  1  system clock, rising edge
nreset  in  1  asynchronous active-low reset
start  in  1  single-cycle pulse, enter RUN
stop  in  1  single-cycle pulse, RUN -> PAUSE
clear  in  1  single-cycle pulse, zero everything, go IDLE
lap  in  1  single-cycle pulse, capture current time
load  in  1  single-cycle pulse, preset time (ignored in RUN)
load_ms  in  10  preset ms
load_s  in  6  preset s
load_min  in  6  preset min
load_hr  in  HR_BITS  preset hr
ms  out  10  elapsed ms, 0..999
s  out  6  elapsed s, 0..59
min  out  6  elapsed min, 0..59
hr  out  HR_BITS  elapsed hr, 0..HR_MAX-1
lap_ms, lap_s, lap_min, lap_hr  out  10/6/6/HR_BITS  captured lap time
lap_valid  out  1  sticky: a lap has been captured since the last clear/reset
running  out  1  high in RUN
overflow  out  1  sticky: full scale was passed (WRAP=1) or reached (WRAP=0)

Behaviour:
- Reset (nreset=0, asynchronous): state IDLE; all time, lap, prescaler, lap_valid, running and overflow = 0.
- FSM states are IDLE (time zero), RUN and PAUSE.
  - IDLE --start--> RUN.
  - RUN --stop--> PAUSE.
  - PAUSE --start--> RUN.
  - any --clear--> IDLE.
  - IDLE/PAUSE --load--> PAUSE.
- Command priority within one cycle: clear > load > stop > start. Lower-priority commands in the same cycle are ignored, except lap (see below).
- Prescaler:
  - Counts 0..CLK_PER_MS-1, only in RUN.
  - Holds its value in PAUSE, so resume is exact.
  - Zeroed by clear, load and reset.
- Increment event: RUN and prescaler == CLK_PER_MS-1. The time registers update on that same edge (outputs are registered, no extra latency).
- Cascade:
  - ms 999 -> 0 with carry into s.
  - s 59 -> 0 with carry into min.
  - min 59 -> 0 with carry into hr.
  - All fields update atomically on the same edge.
- Full scale is HR_MAX-1:59:59.999 plus an increment event.
  - WRAP=1: all fields -> 0, overflow <= 1, stay in RUN.
  - WRAP=0: fields hold at full scale, overflow <= 1, state -> PAUSE. While overflow=1, start is ignored until clear or load.
- Load:
  - Accepted only in IDLE/PAUSE; ignored in RUN.
  - Fields at or above their modulus clamp to modulus-1.
  - Clears overflow; leaves lap registers unchanged.
- Lap:
  - In RUN or PAUSE, copies the current (pre-increment) ms/s/min/hr into the lap_* registers and sets lap_valid.
  - Ignored in IDLE or when clear is active the same cycle.
  - lap together with stop/start/load samples the time value present before that edge.
- running = (state == RUN), registered.
- All arithmetic is unsigned. No field ever leaves its legal range.

Decomposition:
- Shared package: MS_MOD=1000, SEC_MOD=60, MIN_MOD=60, the state encoding (IDLE/RUN/PAUSE) and field widths 10/6/6.
- One sub-module, mod_counter:
  - Parameters: MOD and W.
  - Inputs: en, ld, ld_val.
  - Outputs: q, carry.
  - Instanced four times for ms/s/min/hr.
  - Prescaler is inline.

Test Plan:
- Reset/start: CLK_PER_MS=2. nreset low then high, start, 2000 clocks -> ms=0, s=1, min=0, hr=0, running=1, overflow=0.
- Wrap: WRAP=1, CLK_PER_MS=1. load 99:59:59.999, start, 1 clock -> all fields 0, overflow=1, running=1.
- Saturate: WRAP=0, same preload, start, 3 clocks -> fields stay 99:59:59.999, overflow=1, running=0. A further start is ignored.
- Pause/resume: CLK_PER_MS=4. start, 6 clocks, stop, 10 idle clocks, start, 2 clocks -> ms=2 (prescaler preserved).
- Lap: run to 00:00:01.234, pulse lap -> lap fields read 0:0:1.234, lap_valid=1, main time keeps counting.
- Priority/reset: clear+start+lap in one cycle -> IDLE, all zero, lap_valid=0. Assert nreset mid-RUN -> all outputs 0 asynchronously, before the next clk edge.
